microseq_next_addr: RTL
=======================

Name: microseq_next_addr

Overview:
- Registered microprogram sequencer for the microprogrammed control unit. It replaces the combinational next-address selector.
- Holds the micro-PC (uPC) and selects the next microinstruction address from:
  - zero/fetch
  - up to 3 dispatch tables
  - uPC+1
  - write-back state
  - overflow exception vector
  - micro-subroutine return stack
- Adds stall, exception override, and a bounded call/return stack.
- Sits between the control-store ROM and the dispatch ROMs. `current_address` addresses the control store.

Parameters:
- ADDR_W, 5, width of microinstruction address.
- N_DISPATCH, 3, number of dispatch tables, range 1..3.
- EXC_VECTOR, 30, microaddress of the overflow exception state.
- STACK_DEPTH, 4, micro-return stack entries, range 1..8.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- stall, input, 1, hold uPC and stack (memory wait).
- next_addr_select, input, 3, next-address source code.
- dispatch_addr, input, N_DISPATCH*ADDR_W, flattened dispatch outputs; table k (1-based) is bits [k*ADDR_W-1 : (k-1)*ADDR_W].
- writeback_addr, input, ADDR_W, write-back state address.
- call, input, 1, push uPC+1 on the stack this cycle (micro-subroutine call).
- overflow, input, 1, ALU overflow; forces exception vector.
- current_address, output, ADDR_W, registered uPC.
- saved_address, output, ADDR_W, uPC at the last exception taken.
- exc_taken, output, 1, one-cycle pulse after an exception redirect.
- stack_err, output, 1, sticky overflow/underflow flag.

Behaviour:
- Single clock domain. Reset is synchronous, active-high; all state updates on rising `clk`.
- Reset values: `current_address`=0, `saved_address`=0, `exc_taken`=0, `stack_err`=0, sp=0, stack contents don't-care.
- Priority per cycle: reset > overflow > stall > select.
- overflow=1 (regardless of stall):
  - uPC <= EXC_VECTOR; `saved_address` <= uPC; `exc_taken` <= 1.
  - sp <= 0 (stack flushed); `call` ignored.
- `exc_taken` is 0 on every cycle in which an exception was not taken. It is never held for more than one cycle unless overflow persists.
- stall=1 (no overflow): uPC, sp, stack and `stack_err` all hold; `call` ignored.
- Otherwise uPC <= next, where next is selected by `next_addr_select`:
  - 000 -> 0 (fetch).
  - 001 / 010 / 011 -> dispatch table 1 / 2 / 3. A code above N_DISPATCH yields 0.
  - 100 -> uPC+1, modulo 2^ADDR_W (wraps to 0).
  - 101 -> `writeback_addr`.
  - 110 -> EXC_VECTOR (software-forced vector). Does NOT update `saved_address` or `exc_taken`.
  - 111 -> top of stack (return); sp decrements.
- Return with sp=0 (underflow): next=0, sp stays 0, `stack_err` <= 1.
- call=1 (with no stall and no overflow): push uPC+1 (wrapped), sp increments. The push is independent of the selected next address.
- Push with sp=STACK_DEPTH (overflow): push dropped, sp unchanged, `stack_err` <= 1.
- call=1 with select 111 in the same cycle:
  - Pop then push; top entry is replaced with uPC+1 and sp is unchanged. Not an error, even when sp=STACK_DEPTH.
  - With sp=0: next=0, pushed entry written to slot 0, sp=1, `stack_err` <= 1.
- `stack_err` is cleared only by reset.
- Latency: `current_address` reflects the selection made in the previous cycle. Combinational inputs are sampled one cycle before use.
- Reset mid-stall or mid-exception: reset wins. Next cycle uPC=0 and all flags are clear.
- No latches. Every select code is defined.

Test Plan:
- Reset, then select=100 for 3 cycles -> `current_address` 0,1,2,3. Preload via select=101, `writeback_addr`=31, then select=100 -> 31 then 0 (wrap).
- N_DISPATCH=3, `dispatch_addr`={5'd20,5'd12,5'd6}: select 001/010/011 -> 6/12/20. Rebuild with N_DISPATCH=1: select 011 -> 0.
- uPC=9, stall=1 for 4 cycles with select=100 -> stays 9. overflow=1 during the stall -> next cycle 30, `saved_address`=9, `exc_taken`=1 for one cycle only.
- uPC=4, call=1 with select=001 (table 1=15) -> 15. Then select=111 -> 5. Select=111 again -> 0, `stack_err`=1, stays 1 until reset.
- STACK_DEPTH=4: 5 consecutive calls from uPC 0..4 -> `stack_err`=1 after the 5th. Four returns yield 4,3,2,1.
- reset asserted while overflow=1 and stall=1 -> next cycle all outputs 0. select=110 -> 30 with `exc_taken`=0 and `saved_address` unchanged.

Source files
------------

// File: rtl/microseq_next_addr.sv
// Purpose: registered micro-PC sequencer with dispatch, exception override and call/return stack.
// Latency: one cycle; current_address shows the selection made on the previous rising edge.
// Backpressure: stall holds uPC, stack pointer, stack and stack_err; overflow still redirects.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   stall              - hold sequencer state (memory wait)
//   next_addr_select   - next-address source code
//   dispatch_addr      - flattened dispatch ROM outputs, table k at [k*ADDR_W-1 -: ADDR_W]
//   writeback_addr     - write-back state address
//   call               - push uPC+1 onto the return stack
//   overflow           - ALU overflow, forces EXC_VECTOR
//   current_address    - registered uPC (control store address)
//   saved_address      - uPC captured when the last exception was taken
//   exc_taken          - one-cycle pulse following an exception redirect
//   stack_err          - sticky stack overflow/underflow flag
module microseq_next_addr #(
  parameter int ADDR_W      = 5,
  parameter int N_DISPATCH  = 3,
  parameter int EXC_VECTOR  = 30,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   next_addr_select,
  input  logic [N_DISPATCH*ADDR_W-1:0] dispatch_addr,
  input  logic [ADDR_W-1:0]            writeback_addr,
  input  logic                         call,
  input  logic                         overflow,
  output logic [ADDR_W-1:0]            current_address,
  output logic [ADDR_W-1:0]            saved_address,
  output logic                         exc_taken,
  output logic                         stack_err
);

  // sp ranges 0..STACK_DEPTH inclusive, so it needs one more code than the slot index.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] SEL_FETCH = 3'b000;
  localparam logic [2:0] SEL_D1    = 3'b001;
  localparam logic [2:0] SEL_D2    = 3'b010;
  localparam logic [2:0] SEL_D3    = 3'b011;
  localparam logic [2:0] SEL_INC   = 3'b100;
  localparam logic [2:0] SEL_WB    = 3'b101;
  localparam logic [2:0] SEL_VEC   = 3'b110;
  localparam logic [2:0] SEL_RET   = 3'b111;

  localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_VECTOR);
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] disp_tbl [1:3];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_next;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] upc_inc;
  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              sp_empty;
  logic              sp_full;
  logic              is_ret;
  logic              wr_en;
  logic              err_set;
  logic              advance;

  // Tables beyond N_DISPATCH read as address 0.
  for (genvar k = 1; k <= 3; k++) begin : g_disp
    if (k <= N_DISPATCH) begin : g_used
      assign disp_tbl[k] = dispatch_addr[k*ADDR_W-1 -: ADDR_W];
    end else begin : g_unused
      assign disp_tbl[k] = '0;
    end
  end

  assign upc_inc  = current_address + ADDR_W'(1);
  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == SP_FULL);
  assign is_ret   = (next_addr_select == SEL_RET);
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign top_addr = sp_empty ? '0 : stack_mem[top_idx];
  assign advance  = !overflow && !stall;

  always_comb begin
    next_addr = '0;
    case (next_addr_select)
      SEL_FETCH: next_addr = '0;
      SEL_D1:    next_addr = disp_tbl[1];
      SEL_D2:    next_addr = disp_tbl[2];
      SEL_D3:    next_addr = disp_tbl[3];
      SEL_INC:   next_addr = upc_inc;
      SEL_WB:    next_addr = writeback_addr;
      SEL_VEC:   next_addr = EXC_ADDR;
      SEL_RET:   next_addr = top_addr;
      default:   next_addr = '0;
    endcase
  end

  // Stack update for an advancing cycle. A simultaneous call and return
  // rewrites the top slot in place; on an empty stack the return still
  // underflows but the pushed entry lands in slot 0.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = IDX_W'(sp);
    sp_next = sp;
    err_set = 1'b0;
    if (is_ret && call) begin
      wr_en = 1'b1;
      if (sp_empty) begin
        wr_idx  = '0;
        sp_next = SP_W'(1);
        err_set = 1'b1;
      end else begin
        wr_idx = top_idx;
      end
    end else if (is_ret) begin
      if (sp_empty) begin
        err_set = 1'b1;
      end else begin
        sp_next = sp - SP_W'(1);
      end
    end else if (call) begin
      if (sp_full) begin
        err_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        sp_next = sp + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_address <= '0;
      saved_address   <= '0;
      exc_taken       <= 1'b0;
      stack_err       <= 1'b0;
      sp              <= '0;
    end else if (overflow) begin
      current_address <= EXC_ADDR;
      saved_address   <= current_address;
      exc_taken       <= 1'b1;
      sp              <= '0;
    end else begin
      exc_taken <= 1'b0;
      if (!stall) begin
        current_address <= next_addr;
        sp              <= sp_next;
        if (err_set) begin
          stack_err <= 1'b1;
        end
      end
    end
  end

  // Stack contents need no reset; sp alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (!reset && advance && wr_en) begin
      stack_mem[wr_idx] <= upc_inc;
    end
  end

endmodule
